// File: rtl/inst_buffer_pkg.sv
// Shared instruction-packet type and superscalar sizing for the instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned N               = 3;
  localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int unsigned INST_BUFFER_SZ  = 16;
  localparam int unsigned XLEN            = 32;

  // One fetched instruction with its PC and predicted next PC.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } inst_packet_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch: up to WIDTH pushes
// and WIDTH pops per cycle, with outputs that depend only on registered state.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = INST_BUFFER_SZ,
  parameter int unsigned WIDTH = N
) (
  input  logic                       clock,
  input  logic                       reset,
  input  inst_packet_t               fetch_packets [WIDTH],
  input  logic [NUM_SCALAR_BITS-1:0] num_fetched,
  input  logic [NUM_SCALAR_BITS-1:0] num_dispatched,
  input  logic                       flush,
  output inst_packet_t               inst_buffer_packets [WIDTH],
  output logic [NUM_SCALAR_BITS-1:0] inst_buffer_instructions_valid,
  output logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots,
  output logic [$clog2(DEPTH):0]     inst_buffer_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SB    = NUM_SCALAR_BITS;

  inst_packet_t entries [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] head_next, tail_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] free_slots;
  logic [SB-1:0]    valid_c, spots_c, eff_pop, eff_push;

  // Occupancy-derived outputs, clamped push/pop amounts and next pointers.
  always_comb begin
    valid_c    = '0;
    spots_c    = '0;
    eff_pop    = '0;
    eff_push   = '0;
    free_slots = '0;
    head_next  = head;
    tail_next  = tail;
    count_next = count;

    valid_c    = (count >= CNT_W'(WIDTH)) ? SB'(WIDTH) : SB'(count);
    free_slots = CNT_W'(DEPTH) - count;
    // Spots come from the pre-pop count so a same-cycle pop never frees a slot early.
    spots_c    = (free_slots >= CNT_W'(WIDTH)) ? SB'(WIDTH) : SB'(free_slots);
    eff_pop    = (num_dispatched < valid_c) ? num_dispatched : valid_c;
    eff_push   = (num_fetched < spots_c) ? num_fetched : spots_c;

    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head + PTR_W'(eff_pop);
      tail_next  = tail + PTR_W'(eff_push);
      count_next = count + CNT_W'(eff_push) - CNT_W'(eff_pop);
    end
  end

  // Head window onto the output lanes; lanes past the valid count read as zero.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      inst_buffer_packets[i] = '0;
      if (SB'(i) < valid_c) begin
        inst_buffer_packets[i] = entries[head + PTR_W'(i)];
      end
    end
  end

  assign inst_buffer_instructions_valid = valid_c;
  assign inst_buffer_spots              = spots_c;
  assign inst_buffer_count              = count;

  // Pointer and occupancy state; reset clears it without waiting for an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage is not reset; it is never visible while count is zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!flush && (SB'(i) < eff_push)) begin
        entries[tail + PTR_W'(i)] <= fetch_packets[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed testbench for inst_buffer with DEPTH=8, WIDTH=3.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 3;

  logic                       clock;
  logic                       reset;
  inst_packet_t               fetch_packets [WIDTH];
  logic [NUM_SCALAR_BITS-1:0] num_fetched;
  logic [NUM_SCALAR_BITS-1:0] num_dispatched;
  logic                       flush;
  inst_packet_t               ib_packets [WIDTH];
  logic [NUM_SCALAR_BITS-1:0] ib_valid;
  logic [NUM_SCALAR_BITS-1:0] ib_spots;
  logic [$clog2(DEPTH):0]     ib_count;

  int n_checks = 0;
  int n_pass   = 0;

  inst_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .fetch_packets                  (fetch_packets),
    .num_fetched                    (num_fetched),
    .num_dispatched                 (num_dispatched),
    .flush                          (flush),
    .inst_buffer_packets            (ib_packets),
    .inst_buffer_instructions_valid (ib_valid),
    .inst_buffer_spots              (ib_spots),
    .inst_buffer_count              (ib_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic inst_packet_t mk(input logic [31:0] pc);
    inst_packet_t p;
    p.inst = ~pc;
    p.pc   = pc;
    p.npc  = pc + 32'd4;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_state(input string tag, input int cnt, input int vld, input int spt);
    check({tag, ".count"}, 32'(ib_count), 32'(cnt));
    check({tag, ".valid"}, 32'(ib_valid), 32'(vld));
    check({tag, ".spots"}, 32'(ib_spots), 32'(spt));
  endtask

  task automatic chk_pc(input string tag, input int lane, input logic [31:0] pc);
    check($sformatf("%s.pc%0d", tag, lane), ib_packets[lane].pc, pc);
  endtask

  task automatic chk_zero(input string tag, input int lane);
    check($sformatf("%s.zinst%0d", tag, lane), ib_packets[lane].inst, 32'h0);
    check($sformatf("%s.zpc%0d", tag, lane), ib_packets[lane].pc, 32'h0);
  endtask

  // Drive one cycle of stimulus, clock it, then sample 1 time unit after the edge.
  task automatic step(input int nf, input int nd, input logic fl, input logic [31:0] base);
    for (int i = 0; i < int'(WIDTH); i++) fetch_packets[i] = mk(base + 32'(4 * i));
    num_fetched    = NUM_SCALAR_BITS'(nf);
    num_dispatched = NUM_SCALAR_BITS'(nd);
    flush          = fl;
    @(posedge clock);
    #1;
    num_fetched    = '0;
    num_dispatched = '0;
    flush          = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    num_fetched    = '0;
    num_dispatched = '0;
    flush          = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) fetch_packets[i] = mk(32'hDEAD_0000);
    #12;
    reset = 1'b0;

    // Reset state
    chk_state("rst", 0, 0, 3);
    chk_zero("rst", 0);

    // First push of three, visible next cycle
    step(3, 0, 1'b0, 32'h0);
    chk_state("push3", 3, 3, 3);
    chk_pc("push3", 0, 32'h0);
    chk_pc("push3", 1, 32'h4);
    chk_pc("push3", 2, 32'h8);
    check("push3.inst1", ib_packets[1].inst, ~32'h4);
    check("push3.npc2", ib_packets[2].npc, 32'hC);

    // Fill toward full; excess lanes dropped
    step(3, 0, 1'b0, 32'h10);
    chk_state("fill6", 6, 3, 2);
    step(1, 0, 1'b0, 32'h20);
    chk_state("fill7", 7, 3, 1);
    step(3, 0, 1'b0, 32'h30);
    chk_state("full", 8, 3, 0);
    chk_pc("full", 0, 32'h0);
    step(3, 0, 1'b0, 32'h40);
    chk_state("full_drop", 8, 3, 0);

    // num_dispatched must not alter same-cycle outputs
    num_dispatched = 2'd3;
    #1;
    chk_state("no_comb", 8, 3, 0);
    chk_pc("no_comb", 0, 32'h0);

    // Pop from full
    step(0, 3, 1'b0, 32'h0);
    chk_state("pop3", 5, 3, 3);
    chk_pc("pop3", 0, 32'h10);
    chk_pc("pop3", 2, 32'h18);

    // Push into entries 0..2 while popping: head=6, tail=3, count=5
    step(3, 3, 1'b0, 32'h50);
    chk_state("wrap_a", 5, 3, 3);
    chk_pc("wrap_a", 0, 32'h20);
    chk_pc("wrap_a", 1, 32'h30);
    chk_pc("wrap_a", 2, 32'h50);

    // Consume the wrapping window 6,7,0 while fetching three
    step(3, 3, 1'b0, 32'h60);
    chk_state("wrap_b", 5, 3, 3);
    chk_pc("wrap_b", 0, 32'h54);
    chk_pc("wrap_b", 1, 32'h58);
    chk_pc("wrap_b", 2, 32'h60);

    // Drain to a single entry
    step(0, 3, 1'b0, 32'h0);
    chk_state("drain2", 2, 2, 3);
    step(0, 1, 1'b0, 32'h0);
    chk_state("one", 1, 1, 3);
    chk_pc("one", 0, 32'h68);
    chk_zero("one", 1);

    // Over-dispatch clamps at the valid count
    step(0, 3, 1'b0, 32'h0);
    chk_state("underflow", 0, 0, 3);
    chk_zero("underflow", 0);

    // Push two after empty, head at entry 6
    step(2, 0, 1'b0, 32'h70);
    chk_state("push2", 2, 2, 3);
    chk_pc("push2", 0, 32'h70);
    chk_pc("push2", 1, 32'h74);
    chk_zero("push2", 2);

    // Pop both while pushing three across the wrap
    step(3, 2, 1'b0, 32'h80);
    chk_state("wrap_c", 3, 3, 3);
    chk_pc("wrap_c", 0, 32'h80);
    chk_pc("wrap_c", 2, 32'h88);

    // Flush beats concurrent push and pop
    step(1, 0, 1'b0, 32'h90);
    chk_state("pre_flush", 4, 3, 3);
    step(3, 2, 1'b1, 32'hF0);
    chk_state("flush", 0, 0, 3);
    chk_zero("flush", 0);
    chk_zero("flush", 2);
    step(1, 0, 1'b0, 32'hA0);
    chk_state("post_flush", 1, 1, 3);
    chk_pc("post_flush", 0, 32'hA0);

    // Asynchronous reset mid-cycle with six entries
    step(3, 0, 1'b0, 32'hA4);
    step(2, 0, 1'b0, 32'hB0);
    chk_state("six", 6, 3, 2);
    #3;
    reset = 1'b1;
    #1;
    chk_state("async_rst", 0, 0, 3);
    chk_zero("async_rst", 0);
    #2;
    reset = 1'b0;
    step(3, 0, 1'b0, 32'hC0);
    chk_state("after_rst", 3, 3, 3);
    chk_pc("after_rst", 0, 32'hC0);
    chk_pc("after_rst", 2, 32'hC8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
